// File: rtl/donut_pkg.sv
// Shared raster constants, FSM states and line-buffer entry type for the donut scanline scheduler.
package donut_pkg;

    localparam int unsigned H_W    = 11;
    localparam int unsigned ROW_W  = 10;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned LUMA_W = 6;
    localparam int unsigned STAT_W = 20;
    localparam int unsigned ADDR_W = COL_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic              hit;
        logic [LUMA_W-1:0] luma;
    } line_entry_t;

endpackage

// File: rtl/donut_linebuf.sv
// Two-bank ping-pong line buffer: one write port, one registered read port; address MSB selects the bank.
module donut_linebuf
    import donut_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  line_entry_t       wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output line_entry_t       rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    line_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/donut_line_sched.sv
// Scanline scheduler: renders the next line one column query at a time into a ping-pong
// buffer while the displayed bank streams out. Define DONUT_SCHED_STATS_EN for busy_cycles.
module donut_line_sched
    import donut_pkg::*;
#(
    parameter int unsigned H_DISPLAY = 1220,
    parameter int unsigned H_TOTAL   = 1525,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_TOTAL   = 525,
    parameter int unsigned PIX_SHIFT = 3,
    parameter int unsigned COLS      = H_DISPLAY >> PIX_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [H_W-1:0]    h_count,
    input  logic [ROW_W-1:0]  v_count,
    output logic              core_start,
    output logic [COL_W-1:0]  query_col,
    output logic [ROW_W-1:0]  query_row,
    input  logic              core_done,
    input  logic              core_hit,
    input  logic [LUMA_W-1:0] core_luma,
    output logic              line_setup,
    output logic              frame_step,
    output logic              donut_visible,
    output logic [LUMA_W-1:0] donut_luma,
    output logic              overrun,
    output logic [STAT_W-1:0] busy_cycles
);

    localparam logic [H_W-1:0]   H_LAST  = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_STEP  = H_W'(H_TOTAL - 8);
    localparam logic [H_W-1:0]   H_DISP  = H_W'(H_DISPLAY);
    localparam logic [ROW_W-1:0] V_LAST  = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] V_DISP  = ROW_W'(V_DISPLAY);
    localparam logic [COL_W-1:0] COLS_W  = COL_W'(COLS);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    state_t           state;
    logic             disp_bank;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] fill [2];
    logic             rd_ok_q;
    line_entry_t      rd_data;

    logic             swap_c;
    logic             render_bank_c;
    logic [ROW_W-1:0] next_row_c;
    logic             wr_en_c;
    line_entry_t      wr_data_c;
    logic [COL_W-1:0] rd_col_c;
    logic             rd_ok_c;
    logic             frame_step_c;

    assign swap_c        = (h_count == H_LAST);
    assign render_bank_c = ~disp_bank;
    assign next_row_c    = (v_count == V_LAST) ? '0 : v_count + ROW_W'(1);
    assign wr_en_c       = (state == WAIT) && core_done && !swap_c;
    assign wr_data_c     = {core_hit, core_luma};
    assign rd_col_c      = COL_W'(h_count >> PIX_SHIFT);
    assign rd_ok_c       = (h_count < H_DISP) && (rd_col_c < COLS_W) &&
                           (rd_col_c < fill[disp_bank]) && (v_count < V_DISP);
    assign frame_step_c  = (v_count == V_LAST) && (h_count == H_STEP);

    donut_linebuf u_linebuf (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr ({render_bank_c, col}),
        .wr_data (wr_data_c),
        .rd_addr ({disp_bank, rd_col_c}),
        .rd_data (rd_data)
    );

    // Query FSM; a line swap overrides whatever the FSM was doing, including a same-cycle core_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            disp_bank  <= 1'b0;
            fill[0]    <= '0;
            fill[1]    <= '0;
            col        <= '0;
            query_col  <= '0;
            query_row  <= '0;
            core_start <= 1'b0;
            line_setup <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            line_setup <= 1'b0;
            if (swap_c) begin
                disp_bank       <= render_bank_c;
                fill[disp_bank] <= '0;
                if ((state == ISSUE || state == WAIT) && fill[render_bank_c] < COLS_W) begin
                    overrun <= 1'b1;
                end
                if (next_row_c < V_DISP) begin
                    state      <= SETUP;
                    line_setup <= 1'b1;
                    query_row  <= next_row_c;
                    col        <= '0;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    SETUP: state <= ISSUE;
                    ISSUE: begin
                        core_start <= 1'b1;
                        query_col  <= col;
                        state      <= WAIT;
                    end
                    WAIT: begin
                        if (core_done) begin
                            fill[render_bank_c] <= fill[render_bank_c] + COL_W'(1);
                            if (col == COL_MAX) begin
                                state <= IDLE;
                            end else begin
                                col   <= col + COL_W'(1);
                                state <= ISSUE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Readout: RAM read registered in the line buffer, then gated output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ok_q       <= 1'b0;
            donut_visible <= 1'b0;
            donut_luma    <= '0;
            frame_step    <= 1'b0;
        end else begin
            rd_ok_q       <= rd_ok_c;
            donut_visible <= rd_ok_q & rd_data.hit;
            donut_luma    <= rd_ok_q ? rd_data.luma : '0;
            frame_step    <= frame_step_c;
        end
    end

`ifdef DONUT_SCHED_STATS_EN
    logic [STAT_W-1:0] busy_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt    <= '0;
            busy_cycles <= '0;
        end else if (frame_step_c) begin
            busy_cycles <= busy_cnt;
            busy_cnt    <= '0;
        end else if ((state == ISSUE || state == WAIT) && busy_cnt != '1) begin
            busy_cnt <= busy_cnt + STAT_W'(1);
        end
    end
`else
    assign busy_cycles = '0;
`endif

endmodule
